// File: rtl/rvc_compress_packer.sv
// RV32I -> RVC compressor and halfword packer feeding instruction memory.
// Optional RVC_PACK_STATS_EN adds accepted/compressed instruction counters.
module rvc_compress_packer #(
  parameter logic [15:0] NOP16 = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        pending,
  output logic        comp_hit
`ifdef RVC_PACK_STATS_EN
  ,
  output logic [31:0] stat_in,
  output logic [31:0] stat_comp
`endif
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic {EMPTY, HALF} state_t;

  state_t              state_q;
  logic [HALF_W-1:0]   hold_q;
  logic [WORD_W-1:0]   out_word_q;
  logic                out_valid_q;
  logic                comp_hit_q;
  logic                flush_pend_q;

  logic                accept_c;
  logic                flush_req_c;
  logic                is16_c;
  logic [HALF_W-1:0]   c16_c;

  // Instruction fields
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;
  logic [12:1] imm_b;
  logic [20:1] imm_j;
  logic        rd_c, rs1_c, rs2_c;

  assign opc   = in_instr[6:0];
  assign rd    = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1   = in_instr[19:15];
  assign rs2   = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign imm_i = in_instr[31:20];
  assign imm_s = {in_instr[31:25], in_instr[11:7]};
  assign imm_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8]};
  assign imm_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21]};
  assign rd_c  = (rd[4:3] == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  assign in_ready    = !out_valid_q || out_ready;
  assign accept_c    = in_valid && in_ready;
  assign flush_req_c = flush || flush_pend_q;

  // Compression: immediates are re-encoded bit for bit, no relocation
  always_comb begin
    is16_c = 1'b0;
    c16_c  = '0;
    case (opc)
      7'b0010011: begin
        case (f3)
          3'b000: if (rd == rs1 && imm_i[11:5] == {7{imm_i[5]}} &&
                      (rd != 5'd0 || imm_i == 12'd0)) begin
            is16_c = 1'b1;
            c16_c  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
          end
          3'b111: if (rd == rs1 && rd_c && imm_i[11:5] == {7{imm_i[5]}}) begin
            is16_c = 1'b1;
            c16_c  = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], 2'b01};
          end
          3'b001: if (f7 == 7'd0 && rd == rs1 && rd != 5'd0) begin
            is16_c = 1'b1;
            c16_c  = {3'b000, 1'b0, rd, rs2, 2'b10};
          end
          3'b101: if (rd == rs1 && rd_c && (f7 == 7'b0000000 || f7 == 7'b0100000)) begin
            is16_c = 1'b1;
            c16_c  = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, 2'b01};
          end
          default: ;
        endcase
      end
      7'b0110011: begin
        if (f3 == 3'b000 && f7 == 7'd0 && rd != 5'd0 && rs2 != 5'd0) begin
          if (rs1 == rd) begin
            is16_c = 1'b1;
            c16_c  = {4'b1001, rd, rs2, 2'b10};
          end else if (rs1 == 5'd0) begin
            is16_c = 1'b1;
            c16_c  = {4'b1000, rd, rs2, 2'b10};
          end
        end
      end
      7'b0000011: begin
        if (f3 == 3'b010 && rd_c && rs1_c && imm_i[1:0] == 2'b00 && imm_i[11:7] == 5'd0) begin
          is16_c = 1'b1;
          c16_c  = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end
      end
      7'b0100011: begin
        if (f3 == 3'b010 && rs1_c && rs2_c && imm_s[1:0] == 2'b00 && imm_s[11:7] == 5'd0) begin
          is16_c = 1'b1;
          c16_c  = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
      end
      7'b1100011: begin
        if (f3[2:1] == 2'b00 && rs1_c && rs2 == 5'd0 && imm_b[12:8] == {5{imm_b[12]}}) begin
          is16_c = 1'b1;
          c16_c  = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6],
                    imm_b[2:1], imm_b[5], 2'b01};
        end
      end
      7'b1101111: begin
        if (rd[4:1] == 4'd0 && imm_j[20:11] == {10{imm_j[20]}}) begin
          is16_c = 1'b1;
          c16_c  = {~rd[0], 2'b01, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10], imm_j[6],
                    imm_j[7], imm_j[3:1], imm_j[5], 2'b01};
        end
      end
      7'b1100111: begin
        if (f3 == 3'b000 && rd[4:1] == 4'd0 && rs1 != 5'd0 && imm_i == 12'd0) begin
          is16_c = 1'b1;
          c16_c  = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end
      end
      default: ;
    endcase
  end

  // Packing FSM; a flush that arrives with an accept is remembered until a ready cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      hold_q       <= '0;
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
      comp_hit_q   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      comp_hit_q <= accept_c && is16_c;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept_c) begin
        case (state_q)
          EMPTY: begin
            if (is16_c) begin
              hold_q  <= c16_c;
              state_q <= HALF;
            end else begin
              out_word_q  <= in_instr;
              out_valid_q <= 1'b1;
            end
            flush_pend_q <= flush_req_c && is16_c;
          end
          default: begin
            out_valid_q <= 1'b1;
            if (is16_c) begin
              out_word_q <= {c16_c, hold_q};
              state_q    <= EMPTY;
            end else begin
              out_word_q <= {in_instr[15:0], hold_q};
              hold_q     <= in_instr[31:16];
            end
            flush_pend_q <= flush_req_c && !is16_c;
          end
        endcase
      end else if (flush_req_c) begin
        if (in_ready) begin
          if (state_q == HALF) begin
            out_word_q  <= {NOP16, hold_q};
            out_valid_q <= 1'b1;
            state_q     <= EMPTY;
          end
          flush_pend_q <= 1'b0;
        end else begin
          flush_pend_q <= (state_q == HALF);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign pending   = (state_q == HALF);
  assign comp_hit  = comp_hit_q;

`ifdef RVC_PACK_STATS_EN
  logic [31:0] stat_in_q, stat_comp_q;

  // Wrapping activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_in_q   <= '0;
      stat_comp_q <= '0;
    end else if (accept_c) begin
      stat_in_q <= stat_in_q + 32'(1);
      if (is16_c) stat_comp_q <= stat_comp_q + 32'(1);
    end
  end

  assign stat_in   = stat_in_q;
  assign stat_comp = stat_comp_q;
`endif

endmodule

// File: tb/tb_rvc_compress_packer.sv
// Directed bench for rvc_compress_packer: compression forms, packing, flush, backpressure, reset.
module tb_rvc_compress_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        pending;
  logic        comp_hit;
`ifdef RVC_PACK_STATS_EN
  logic [31:0] stat_in;
  logic [31:0] stat_comp;
`endif

  int checks = 0;
  int errors = 0;

  rvc_compress_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .pending   (pending),
    .comp_hit  (comp_hit)
`ifdef RVC_PACK_STATS_EN
    ,
    .stat_in   (stat_in),
    .stat_comp (stat_comp)
`endif
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    in_instr = ins;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_word !== 32'h0) begin errors++; $display("FAIL reset_out_word: got %h want 00000000", out_word); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending); end
    checks++; if (comp_hit !== 1'b0) begin errors++; $display("FAIL reset_comp_hit: got %b want 0", comp_hit); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_flush();
    send(32'h00140413);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL t1_pending: got %b want 1", pending); end
    checks++; if (comp_hit !== 1'b1) begin errors++; $display("FAIL t1_comp_hit: got %b want 1", comp_hit); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_no_out: got %b want 0", out_valid); end
    do_flush();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_out_valid: got %b want 1", out_valid); end
    checks++; if (out_word !== 32'h00010405) begin errors++; $display("FAIL t1_word: got %h want 00010405", out_word); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL t1_pending_clr: got %b want 0", pending); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_pair();
    send(32'h00B50533);
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL t2_pending: got %b want 1", pending); end
    send(32'h00852483);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_out_valid: got %b want 1", out_valid); end
    checks++; if (out_word !== 32'h4504952E) begin errors++; $display("FAIL t2_word: got %h want 4504952E", out_word); end
    checks++; if (comp_hit !== 1'b1) begin errors++; $display("FAIL t2_comp_hit: got %b want 1", comp_hit); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL t2_pending_clr: got %b want 0", pending); end
    cycle();
  endtask

  task automatic test_mixed();
    send(32'h00140413);
    send(32'h007302B3);
    checks++; if (out_word !== 32'h02B30405) begin errors++; $display("FAIL t3_word0: got %h want 02B30405", out_word); end
    checks++; if (comp_hit !== 1'b0) begin errors++; $display("FAIL t3_comp_hit: got %b want 0", comp_hit); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL t3_pending: got %b want 1", pending); end
    do_flush();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_out_valid1: got %b want 1", out_valid); end
    checks++; if (out_word !== 32'h00010073) begin errors++; $display("FAIL t3_word1: got %h want 00010073", out_word); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL t3_pending_clr: got %b want 0", pending); end
    cycle();
  endtask

  task automatic test_compress_forms();
    logic [31:0] first [4];
    logic [31:0] second[4];
    logic [31:0] word  [4];
    // jr x1 + beqz x8,8 ; sw x9,4(x8) + jal x1,16 ; srai x10,3 + nop ; mv x5,x6 + andi x9,-1
    first  = '{32'h00008067, 32'h00942223, 32'h40355513, 32'h006002B3};
    second = '{32'h00040463, 32'h010000EF, 32'h00000013, 32'hFFF4F493};
    word   = '{32'hC4018082, 32'h2801C044, 32'h0001850D, 32'h98FD829A};
    for (int i = 0; i < 4; i++) begin
      send(first[i]);
      checks++; if (comp_hit !== 1'b1) begin errors++; $display("FAIL form%0d_first_hit: got %b want 1", i, comp_hit); end
      send(second[i]);
      checks++; if (comp_hit !== 1'b1) begin errors++; $display("FAIL form%0d_second_hit: got %b want 1", i, comp_hit); end
      checks++; if (out_word !== word[i]) begin errors++; $display("FAIL form%0d_word: got %h want %h", i, out_word, word[i]); end
    end
    cycle();
  endtask

  task automatic test_edges();
    logic [31:0] edge_in[4];
    // addi x8,x8,32 ; lw x9,128(x10) ; beq x8,x1,8 ; jalr x1,0(x0)
    edge_in = '{32'h02040413, 32'h08052483, 32'h00140463, 32'h000000E7};
    for (int i = 0; i < 4; i++) begin
      send(edge_in[i]);
      checks++; if (comp_hit !== 1'b0) begin errors++; $display("FAIL edge%0d_hit: got %b want 0", i, comp_hit); end
      checks++; if (out_valid !== 1'b1 || out_word !== edge_in[i]) begin
        errors++; $display("FAIL edge%0d_word: got v=%b %h want v=1 %h", i, out_valid, out_word, edge_in[i]);
      end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL edge%0d_pending: got %b want 0", i, pending); end
    end
    cycle();
  endtask

  task automatic test_flush_with_accept();
    send(32'h00140413);
    in_valid = 1'b1; in_instr = 32'h007302B3; flush = 1'b1;
    cycle();
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (out_word !== 32'h02B30405) begin errors++; $display("FAIL fa_word0: got %h want 02B30405", out_word); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL fa_pending: got %b want 1", pending); end
    cycle();
    checks++; if (out_valid !== 1'b1 || out_word !== 32'h00010073) begin
      errors++; $display("FAIL fa_word1: got v=%b %h want v=1 00010073", out_valid, out_word);
    end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL fa_pending_clr: got %b want 0", pending); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fa_no_extra: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    send(32'h00B50533);
    send(32'h007302B3);
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00852483;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready: got %b want 0", i, in_ready); end
      checks++; if (out_valid !== 1'b1 || out_word !== 32'h02B3952E) begin
        errors++; $display("FAIL bp%0d_stable: got v=%b %h want v=1 02B3952E", i, out_valid, out_word);
      end
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL bp%0d_pending: got %b want 1", i, pending); end
    end
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_word !== 32'h45040073) begin
      errors++; $display("FAIL bp_release_word: got v=%b %h want v=1 45040073", out_valid, out_word);
    end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bp_release_pending: got %b want 0", pending); end
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    send(32'h00140413);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL t6_pending: got %b want 0", pending); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_out_valid: got %b want 0", out_valid); end
    do_flush();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_flush_empty: got %b want 0", out_valid); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL t6_pending_after: got %b want 0", pending); end
  endtask

  initial begin
    test_reset();
    test_single_flush();
    test_pair();
    test_mixed();
    test_compress_forms();
    test_edges();
    test_flush_with_accept();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
